// File: rtl/bcd_add_arbiter.sv
// bcd_add_arbiter: two requesters share one 4-digit ripple BCD adder.
// The granted operand pair is added and captured in a single-entry result
// register with a valid/ready handshake toward the consumer. The result
// register may be drained and refilled in the same cycle.
module bcd_add_arbiter #(
  parameter logic RR_EN = 1'b1   // 1: round-robin, 0: fixed priority (req0 first)
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_ci,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_ci,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sum,
  output logic        res_co,
  output logic        res_id,
  output logic        res_err
);

  // Registered state
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_sum_q, res_sum_d;
  logic        res_co_q, res_co_d;
  logic        res_id_q, res_id_d;
  logic        res_err_q, res_err_d;
  logic        rr_last_q, rr_last_d;

  // Arbitration and datapath nets
  logic        sel;
  logic        grant0, grant1;
  logic        can_accept;
  logic        xfer;
  logic [15:0] op_a, op_b;
  logic        op_ci;
  logic [4:0]  carry;
  logic [15:0] add_sum;
  logic [7:0]  nib_bad;

  // Grant choice: depends only on valids and the pointer, never on readies,
  // so res_ready cannot loop back into the selection.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      if (RR_EN) sel = (rr_last_q == 1'b1) ? 1'b0 : 1'b1;
      else       sel = 1'b0;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign grant0     = req0_valid && (sel == 1'b0);
  assign grant1     = req1_valid && (sel == 1'b1);
  assign can_accept = !res_valid_q || res_ready;
  // Readies are suppressed while reset is held so nothing is acknowledged.
  assign req0_ready = nrst && can_accept && grant0;
  assign req1_ready = nrst && can_accept && grant1;
  assign xfer       = req0_ready || req1_ready;

  // Operand mux feeding the shared adder
  always_comb begin
    op_a  = req0_a;
    op_b  = req0_b;
    op_ci = req0_ci;
    if (sel) begin
      op_a  = req1_a;
      op_b  = req1_b;
      op_ci = req1_ci;
    end
  end

  assign carry[0] = op_ci;

  // Four cascaded 1-digit BCD adders; a binary digit sum above 9 is
  // corrected by +6 and produces a decimal carry into the next digit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [4:0] raw;
      assign raw          = {1'b0, op_a[gi*4 +: 4]} + {1'b0, op_b[gi*4 +: 4]} + {4'b0000, carry[gi]};
      assign carry[gi+1]  = (raw > 5'd9);
      assign add_sum[gi*4 +: 4] = carry[gi+1] ? (raw[3:0] + 4'd6) : raw[3:0];
      assign nib_bad[2*gi]      = (op_a[gi*4 +: 4] > 4'd9);
      assign nib_bad[2*gi+1]    = (op_b[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  // Next-state for the result register and round-robin pointer
  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_co_d    = res_co_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    rr_last_d   = rr_last_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_sum;
      res_co_d    = carry[4];
      res_id_d    = sel;
      res_err_d   = |nib_bad;
      rr_last_d   = sel;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers; reset leaves rr_last=1 so requester 0 wins first contention
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= 16'h0000;
      res_co_q    <= 1'b0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_co_q    <= res_co_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_co    = res_co_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_bcd_add_arbiter.sv
// Directed testbench for bcd_add_arbiter. Two instances share the stimulus:
// dut_rr (round-robin) and dut_fx (fixed priority).
module tb_bcd_add_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ci = 1'b0, req1_ci = 1'b0;
  logic        res_ready = 1'b0;

  logic        rr_ready0, rr_ready1, rr_valid, rr_co, rr_id, rr_err;
  logic [15:0] rr_sum;
  logic        fx_ready0, fx_ready1, fx_valid, fx_co, fx_id, fx_err;
  logic [15:0] fx_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_add_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .nrst(nrst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci), .req0_ready(rr_ready0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci), .req1_ready(rr_ready1),
    .res_valid(rr_valid), .res_ready(res_ready), .res_sum(rr_sum), .res_co(rr_co),
    .res_id(rr_id), .res_err(rr_err)
  );

  bcd_add_arbiter #(.RR_EN(1'b0)) dut_fx (
    .clk(clk), .nrst(nrst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci), .req0_ready(fx_ready0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci), .req1_ready(fx_ready1),
    .res_valid(fx_valid), .res_ready(res_ready), .res_sum(fx_sum), .res_co(fx_co),
    .res_id(fx_id), .res_err(fx_err)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready  = 1'b1;
    #12;
    n_checks++; if (rr_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b exp 0", rr_valid); end
    n_checks++; if (rr_sum !== 16'h0000)  begin n_fail++; $display("FAIL reset_sum got %h exp 0000", rr_sum); end
    n_checks++; if ({rr_co, rr_id, rr_err} !== 3'b000) begin n_fail++; $display("FAIL reset_co_id_err got %b exp 000", {rr_co, rr_id, rr_err}); end
    n_checks++; if ({rr_ready0, rr_ready1} !== 2'b00) begin n_fail++; $display("FAIL reset_readies got %b exp 00", {rr_ready0, rr_ready1}); end
    idle_inputs();
    @(negedge clk);
    nrst = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h5678; req0_ci = 1'b0;
    res_ready  = 1'b1;
    #1;
    n_checks++; if ({rr_ready0, rr_ready1} !== 2'b10) begin n_fail++; $display("FAIL single_ready got %b exp 10", {rr_ready0, rr_ready1}); end
    step();
    req0_valid = 1'b0;
    $display("txn single: id=%0d sum=%h co=%b err=%b", rr_id, rr_sum, rr_co, rr_err);
    n_checks++; if (rr_valid !== 1'b1)   begin n_fail++; $display("FAIL single_valid got %b exp 1", rr_valid); end
    n_checks++; if (rr_sum !== 16'h6912) begin n_fail++; $display("FAIL single_sum got %h exp 6912", rr_sum); end
    n_checks++; if ({rr_co, rr_id, rr_err} !== 3'b000) begin n_fail++; $display("FAIL single_co_id_err got %b exp 000", {rr_co, rr_id, rr_err}); end
    step();
    n_checks++; if (rr_valid !== 1'b0)   begin n_fail++; $display("FAIL drain_valid got %b exp 0", rr_valid); end
    n_checks++; if (rr_sum !== 16'h6912) begin n_fail++; $display("FAIL drain_sum_kept got %h exp 6912", rr_sum); end
  endtask

  task automatic test_carry();
    req1_valid = 1'b1; req1_a = 16'h9999; req1_b = 16'h0000; req1_ci = 1'b1;
    res_ready  = 1'b1;
    step();
    req1_valid = 1'b0;
    $display("txn carry: id=%0d sum=%h co=%b", rr_id, rr_sum, rr_co);
    n_checks++; if (rr_sum !== 16'h0000) begin n_fail++; $display("FAIL carry_sum got %h exp 0000", rr_sum); end
    n_checks++; if ({rr_valid, rr_co, rr_id} !== 3'b111) begin n_fail++; $display("FAIL carry_valid_co_id got %b exp 111", {rr_valid, rr_co, rr_id}); end
    step();
  endtask

  task automatic test_contention();
    logic [3:0]  exp_id;
    exp_id = 4'b1010;   // bit i = expected res_id of result i (0,1,0,1)
    req0_a = 16'h0001; req0_b = 16'h0001; req0_ci = 1'b0;   // 0002
    req1_a = 16'h0010; req1_b = 16'h0020; req1_ci = 1'b0;   // 0030
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("txn contention %0d: rr id=%0d sum=%h fx id=%0d sum=%h", i, rr_id, rr_sum, fx_id, fx_sum);
      n_checks++; if (rr_valid !== 1'b1) begin n_fail++; $display("FAIL cont_rr_valid[%0d] got %b exp 1", i, rr_valid); end
      n_checks++; if (rr_id !== exp_id[i]) begin n_fail++; $display("FAIL cont_rr_id[%0d] got %b exp %b", i, rr_id, exp_id[i]); end
      n_checks++; if (rr_sum !== (exp_id[i] ? 16'h0030 : 16'h0002)) begin n_fail++; $display("FAIL cont_rr_sum[%0d] got %h exp %h", i, rr_sum, exp_id[i] ? 16'h0030 : 16'h0002); end
      n_checks++; if ({fx_valid, fx_id} !== 2'b10) begin n_fail++; $display("FAIL cont_fx_valid_id[%0d] got %b exp 10", i, {fx_valid, fx_id}); end
      n_checks++; if (fx_sum !== 16'h0002) begin n_fail++; $display("FAIL cont_fx_sum[%0d] got %h exp 0002", i, fx_sum); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    // Pointer last granted req1, so req0 is taken first, then held back.
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready  = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      $display("txn stall %0d: valid=%b id=%0d sum=%h", i, rr_valid, rr_id, rr_sum);
      n_checks++; if ({rr_valid, rr_id} !== 2'b10) begin n_fail++; $display("FAIL stall_valid_id[%0d] got %b exp 10", i, {rr_valid, rr_id}); end
      n_checks++; if (rr_sum !== 16'h0002) begin n_fail++; $display("FAIL stall_sum[%0d] got %h exp 0002", i, rr_sum); end
      n_checks++; if ({rr_ready0, rr_ready1} !== 2'b00) begin n_fail++; $display("FAIL stall_readies[%0d] got %b exp 00", i, {rr_ready0, rr_ready1}); end
      step();
    end
    res_ready = 1'b1;
    #1;
    n_checks++; if ({rr_ready0, rr_ready1} !== 2'b01) begin n_fail++; $display("FAIL refill_readies got %b exp 01", {rr_ready0, rr_ready1}); end
    step();
    idle_inputs();
    $display("txn refill: valid=%b id=%0d sum=%h", rr_valid, rr_id, rr_sum);
    n_checks++; if ({rr_valid, rr_id} !== 2'b11) begin n_fail++; $display("FAIL refill_valid_id got %b exp 11", {rr_valid, rr_id}); end
    n_checks++; if (rr_sum !== 16'h0030) begin n_fail++; $display("FAIL refill_sum got %h exp 0030", rr_sum); end
    step();
  endtask

  task automatic test_invalid_digit();
    req0_valid = 1'b1; req0_a = 16'h00A0; req0_b = 16'h0001; req0_ci = 1'b0;
    res_ready  = 1'b1;
    step();
    $display("txn invalid: err=%b sum=%h", rr_err, rr_sum);
    n_checks++; if ({rr_valid, rr_err} !== 2'b11) begin n_fail++; $display("FAIL invalid_err got %b exp 11", {rr_valid, rr_err}); end
    req0_a = 16'h0005; req0_b = 16'h0004;
    step();
    req0_valid = 1'b0;
    $display("txn valid_after: err=%b sum=%h", rr_err, rr_sum);
    n_checks++; if (rr_err !== 1'b0)     begin n_fail++; $display("FAIL clean_err got %b exp 0", rr_err); end
    n_checks++; if (rr_sum !== 16'h0009) begin n_fail++; $display("FAIL clean_sum got %h exp 0009", rr_sum); end
    step();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b1; req1_a = 16'h0042; req1_b = 16'h0011; req1_ci = 1'b0;
    res_ready  = 1'b0;
    step();
    req1_valid = 1'b0;
    n_checks++; if (rr_valid !== 1'b1) begin n_fail++; $display("FAIL pending_valid got %b exp 1", rr_valid); end
    #2;
    nrst = 1'b0;
    #1;
    $display("txn mid reset: valid=%b sum=%h", rr_valid, rr_sum);
    n_checks++; if (rr_valid !== 1'b0)   begin n_fail++; $display("FAIL midrst_valid got %b exp 0", rr_valid); end
    n_checks++; if (rr_sum !== 16'h0000) begin n_fail++; $display("FAIL midrst_sum got %h exp 0000", rr_sum); end
    @(negedge clk);
    nrst = 1'b1;
    req0_a = 16'h0001; req0_b = 16'h0001; req1_a = 16'h0010; req1_b = 16'h0020;
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready  = 1'b1;
    #1;
    n_checks++; if ({rr_ready0, rr_ready1} !== 2'b10) begin n_fail++; $display("FAIL postrst_readies got %b exp 10", {rr_ready0, rr_ready1}); end
    step();
    idle_inputs();
    $display("txn post reset: id=%0d sum=%h", rr_id, rr_sum);
    n_checks++; if ({rr_valid, rr_id} !== 2'b10) begin n_fail++; $display("FAIL postrst_valid_id got %b exp 10", {rr_valid, rr_id}); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_back_to_back();
    test_invalid_digit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
